ddr_tx_serializer: RTL

DDR_TX_SERIALIZER -- requirements
Module: ddr_tx_serializer

---
 rtl/ddr_tx_serializer_if.sv | 40 ++++
 rtl/ddr_tx_serializer.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/ddr_tx_serializer_if.sv
// ---------------------------------------------------------------------------
// ddr_tx_serializer_if : source/ODDR-facing bundle of the DDR TX serializer
// Optional DDR_TX_PARITY_EN adds the ddr_par lane-parity signal.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface ddr_tx_serializer_if #(
  parameter int DATA_W = 8
);
  logic                  in_valid;
  logic [2*DATA_W-1:0]   in_data;
  logic                  in_ready;
  logic                  train_req;
  logic [DATA_W-1:0]     ddr_pos;
  logic [DATA_W-1:0]     ddr_neg;
  logic                  ddr_valid;
  logic                  training;
`ifdef DDR_TX_PARITY_EN
  logic [1:0]            ddr_par;
`endif

  modport master (
`ifdef DDR_TX_PARITY_EN
    input  ddr_par,
`endif
    output in_valid, in_data, train_req,
    input  in_ready, ddr_pos, ddr_neg, ddr_valid, training
  );

  modport slave (
`ifdef DDR_TX_PARITY_EN
    output ddr_par,
`endif
    input  in_valid, in_data, train_req,
    output in_ready, ddr_pos, ddr_neg, ddr_valid, training
  );
endinterface

`default_nettype wire

// File: rtl/ddr_tx_serializer.sv
// ---------------------------------------------------------------------------
// ddr_tx_serializer : FIFO-buffered word-to-DDR-half splitter with training
// bursts. Optional DDR_TX_PARITY_EN adds registered even parity per half.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ddr_tx_serializer #(
  parameter int DATA_W       = 8,
  parameter int FIFO_DEPTH   = 4,
  parameter int TRAIN_CYCLES = 16
) (
  input  logic               clk,
  input  logic               rst,
  ddr_tx_serializer_if.slave bus
);

  localparam int c_AW = $clog2(FIFO_DEPTH);
  localparam int c_CW = $clog2(TRAIN_CYCLES + 1);
  localparam logic [c_CW-1:0]     c_CNT_INIT  = c_CW'(TRAIN_CYCLES);
  localparam logic [c_CW-1:0]     c_CNT_ONE   = c_CW'(1);
  // The A5 byte is repeated across wide lanes and truncated for narrow ones.
  localparam logic [8*DATA_W-1:0] c_PAT_REP   = {DATA_W{8'hA5}};
  localparam logic [DATA_W-1:0]   c_TRAIN_PAT = c_PAT_REP[DATA_W-1:0];

  typedef enum logic [0:0] {
    S_TRAIN  = 1'b0,
    S_STREAM = 1'b1
  } state_t;

  logic [2*DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [c_AW:0]       r_wr_ptr;
  logic [c_AW:0]       r_rd_ptr;
  state_t              r_state;
  logic [c_CW-1:0]     r_cnt;
  logic [DATA_W-1:0]   r_pos;
  logic [DATA_W-1:0]   r_neg;
  logic                r_valid;
  logic                r_training;

  logic                w_empty;
  logic                w_full;
  logic                w_push;
  logic                w_pop;
  logic [2*DATA_W-1:0] w_head;
  logic [DATA_W-1:0]   w_pos_next;
  logic [DATA_W-1:0]   w_neg_next;
  logic                w_valid_next;
  logic                w_training_next;

  // Extra MSB on each pointer separates full from empty when indices match.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                   (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
  assign w_push  = bus.in_valid && !w_full;
  assign w_pop   = (r_state == S_STREAM) && !w_empty && !bus.train_req;
  assign w_head  = r_mem[r_rd_ptr[c_AW-1:0]];

  always_comb begin
    w_pos_next      = '0;
    w_neg_next      = '0;
    w_valid_next    = 1'b0;
    w_training_next = 1'b0;
    if (r_state == S_TRAIN) begin
      w_pos_next      = c_TRAIN_PAT;
      w_neg_next      = ~c_TRAIN_PAT;
      w_training_next = 1'b1;
    end else if (w_pop) begin
      w_pos_next   = w_head[DATA_W-1:0];
      w_neg_next   = w_head[2*DATA_W-1:DATA_W];
      w_valid_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[c_AW-1:0]] <= bus.in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_TRAIN;
      r_cnt      <= c_CNT_INIT;
      r_pos      <= '0;
      r_neg      <= '0;
      r_valid    <= 1'b0;
      r_training <= 1'b1;
    end else begin
      r_pos      <= w_pos_next;
      r_neg      <= w_neg_next;
      r_valid    <= w_valid_next;
      r_training <= w_training_next;
      case (r_state)
        S_TRAIN: begin
          if (bus.train_req) begin
            r_cnt <= c_CNT_INIT;
          end else if (r_cnt == c_CNT_ONE) begin
            r_state <= S_STREAM;
            r_cnt   <= c_CNT_INIT;
          end else begin
            r_cnt <= r_cnt - c_CNT_ONE;
          end
        end
        S_STREAM: begin
          if (bus.train_req) begin
            r_state <= S_TRAIN;
            r_cnt   <= c_CNT_INIT;
          end
        end
        default: begin
          r_state <= S_TRAIN;
          r_cnt   <= c_CNT_INIT;
        end
      endcase
    end
  end

`ifdef DDR_TX_PARITY_EN
  logic [1:0] r_par;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_par <= 2'b00;
    end else begin
      r_par <= {^w_neg_next, ^w_pos_next};
    end
  end

  assign bus.ddr_par = r_par;
`endif

  assign bus.in_ready  = !w_full;
  assign bus.ddr_pos   = r_pos;
  assign bus.ddr_neg   = r_neg;
  assign bus.ddr_valid = r_valid;
  assign bus.training  = r_training;

endmodule

`default_nettype wire
